byte_mem_server: RTL and testbench

- Byte-wide memory responder that sits directly upstream and downstream of the kernel wrapper.
- Serves the wrapper's read_enable/read_ready/finish_read handshake, which loads input bytes.
- Accepts the wrapper's write_enable/write_ready/finish_write handshake, which stores results back.
- A host port preloads and dumps memory while both handshake channels are idle.

---
 rtl/bf_mem_pkg.sv | 35 +++
 rtl/mem_stream_chan.sv | 70 +++++++
 rtl/byte_mem_server.sv | 141 ++++++++++++++
 tb/tb_byte_mem_server.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf_mem_pkg
// Description : Shared definitions for byte_mem_server: stream-channel state
//               encodings, the ready-word constant, the latency counter width
//               and an address range helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bf_mem_pkg;

    // Latency counter width; supports latencies 1..15
    localparam int LAT_W = 4;

    // Read channel states
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;
    localparam logic [1:0] R_ACK  = 2'd3;

    // Write channel states (same encoding, the channel FSM is shared)
    localparam logic [1:0] W_IDLE = R_IDLE;
    localparam logic [1:0] W_WAIT = R_WAIT;
    localparam logic [1:0] W_RESP = R_RESP;
    localparam logic [1:0] W_ACK  = R_ACK;

    // Value presented on a ready port for one cycle
    localparam logic [63:0] READY_ONE = 64'd1;

    // True when a 64-bit byte address has bits set above the memory range
    function automatic logic addr_out_of_range(input logic [63:0] addr, input int aw);
        return (addr >> aw) != 64'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stream_chan.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_chan
// Description : One latency / ready / acknowledge handshake FSM. IDLE waits
//               for enable, WAIT counts LAT cycles, RESP is the single ready
//               cycle, ACK waits for finish (next item) or enable low (done).
// Ports       : clk, reset (async, active-low), enable, finish in;
//               state (current state), latch (address capture strobe),
//               fetch (last WAIT cycle) out.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stream_chan
    import bf_mem_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       finish,
    output logic [1:0] state,
    output logic       latch,
    output logic       fetch
);

    localparam logic [LAT_W-1:0] c_LAT_LOAD = LAT_W'(LAT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [LAT_W-1:0] r_lat_cnt;

    // State register and latency counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= R_IDLE;
            r_lat_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (latch) begin
                r_lat_cnt <= c_LAT_LOAD;
            end else if ((r_state == R_WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
        end
    end

    // Next-state logic; finish wins over enable dropping in ACK
    always_comb begin
        w_next = r_state;
        case (r_state)
            R_IDLE:  if (enable) w_next = R_WAIT;
            R_WAIT:  if (r_lat_cnt == '0) w_next = R_RESP;
            R_RESP:  w_next = R_ACK;
            R_ACK: begin
                if (finish)       w_next = R_WAIT;
                else if (!enable) w_next = R_IDLE;
            end
            default: w_next = R_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        state = r_state;
        latch = ((r_state == R_IDLE) && enable) || ((r_state == R_ACK) && finish);
        fetch = (r_state == R_WAIT) && (r_lat_cnt == '0);
    end

endmodule
`default_nettype wire

// File: rtl/byte_mem_server.sv
`default_nettype none
// ============================================================================
// Module      : byte_mem_server
// Description : Byte-wide memory responder for a kernel wrapper. Serves a
//               read stream and a write stream through two independent
//               latency/ready/ack channels and exposes a host port for
//               preload/dump while both channels are idle.
// Ports       : clk, reset (async, active-low);
//               read_*  : read stream handshake, read_ready / read_data out;
//               write_* : write stream handshake, write_ready out;
//               host_*  : host write strobe/address/data, registered rdata,
//                         host_ready (both channels idle);
//               rd_count / wr_count : bytes served / committed;
//               err     : sticky protocol/range error.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_mem_server
    import bf_mem_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_enable,
    input  logic [63:0]       read_addr,
    input  logic [63:0]       read_size,
    input  logic              finish_read,
    output logic [63:0]       read_ready,
    output logic [7:0]        read_data,
    input  logic              write_enable,
    input  logic [63:0]       write_addr,
    input  logic [63:0]       write_size,
    input  logic [7:0]        write_data,
    input  logic              finish_write,
    output logic [63:0]       write_ready,
    input  logic              host_we,
    input  logic [MEM_AW-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_ready,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic              err
);

    localparam int c_DEPTH = 2 ** MEM_AW;

    logic [7:0]        r_mem [c_DEPTH];
    logic [MEM_AW-1:0] r_rd_addr;
    logic [7:0]        r_read_data;
    logic [7:0]        r_host_rdata;
    logic [31:0]       r_rd_count;
    logic [31:0]       r_wr_count;
    logic              r_err;

    logic [1:0] w_rd_state;
    logic [1:0] w_wr_state;
    logic       w_rd_latch;
    logic       w_rd_fetch;
    logic       w_wr_latch;
    logic       w_wr_fetch_unused;
    logic       w_host_ready;
    logic       w_wr_commit;
    logic       w_err_set;

    mem_stream_chan #(.LAT(RD_LAT)) u_rd_chan (
        .clk    (clk),
        .reset  (reset),
        .enable (read_enable),
        .finish (finish_read),
        .state  (w_rd_state),
        .latch  (w_rd_latch),
        .fetch  (w_rd_fetch)
    );

    mem_stream_chan #(.LAT(WR_LAT)) u_wr_chan (
        .clk    (clk),
        .reset  (reset),
        .enable (write_enable),
        .finish (finish_write),
        .state  (w_wr_state),
        .latch  (w_wr_latch),
        .fetch  (w_wr_fetch_unused)
    );

    assign w_host_ready = (w_rd_state == R_IDLE) && (w_wr_state == W_IDLE);
    assign w_wr_commit  = (w_wr_state == W_RESP);

    // Error sources: bad size or out-of-range address at an address capture,
    // a finish pulse outside ACK, or a host write while a channel is busy.
    assign w_err_set =
        (w_rd_latch && ((read_size != 64'd1) || addr_out_of_range(read_addr, MEM_AW))) ||
        (w_wr_latch && ((write_size != 64'd1) || addr_out_of_range(write_addr, MEM_AW))) ||
        (finish_read && (w_rd_state != R_ACK)) ||
        (finish_write && (w_wr_state != W_ACK)) ||
        (host_we && !w_host_ready);

    // Memory array and host read port; contents survive reset. The write
    // commit uses the live write address/data presented in the RESP cycle.
    // Host writes can only land when the write channel is idle, so the two
    // write sources never compete.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            r_mem[write_addr[MEM_AW-1:0]] <= write_data;
        end else if (host_we && w_host_ready) begin
            r_mem[host_addr] <= host_wdata;
        end
        r_host_rdata <= r_mem[host_addr];
    end

    // Read data path, counters and sticky error. A read fetched on the same
    // edge as a write commit to the same byte sees the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_addr   <= '0;
            r_read_data <= '0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_rd_latch)               r_rd_addr   <= read_addr[MEM_AW-1:0];
            if (w_rd_fetch)               r_read_data <= r_mem[r_rd_addr];
            if (w_rd_state == R_RESP)     r_rd_count  <= r_rd_count + 32'd1;
            if (w_wr_commit)              r_wr_count  <= r_wr_count + 32'd1;
            if (w_err_set)                r_err       <= 1'b1;
        end
    end

    assign read_ready  = (w_rd_state == R_RESP) ? READY_ONE : 64'd0;
    assign write_ready = w_wr_commit ? READY_ONE : 64'd0;
    assign read_data   = r_read_data;
    assign host_rdata  = r_host_rdata;
    assign host_ready  = w_host_ready;
    assign rd_count    = r_rd_count;
    assign wr_count    = r_wr_count;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_byte_mem_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_mem_server
// Description : Self-checking bench for byte_mem_server. A wrapper model
//               drives read/write streams; expected bytes come from a plain
//               array mirror of memory, expected counts from per-transaction
//               tallies, and expected latency from RD_LAT/WR_LAT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_mem_server;

    localparam int AW  = 10;
    localparam int RDL = 2;
    localparam int WRL = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read_enable = 1'b0;
    logic [63:0] read_addr = '0;
    logic [63:0] read_size = 64'd1;
    logic        finish_read = 1'b0;
    logic [63:0] read_ready;
    logic [7:0]  read_data;
    logic        write_enable = 1'b0;
    logic [63:0] write_addr = '0;
    logic [63:0] write_size = 64'd1;
    logic [7:0]  write_data = '0;
    logic        finish_write = 1'b0;
    logic [63:0] write_ready;
    logic        host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic [7:0]  host_rdata;
    logic        host_ready;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic        err;

    always #5 clk = ~clk;

    byte_mem_server #(.MEM_AW(AW), .RD_LAT(RDL), .WR_LAT(WRL)) dut (
        .clk(clk), .reset(reset),
        .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
        .finish_read(finish_read), .read_ready(read_ready), .read_data(read_data),
        .write_enable(write_enable), .write_addr(write_addr), .write_size(write_size),
        .write_data(write_data), .finish_write(finish_write), .write_ready(write_ready),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ready(host_ready),
        .rd_count(rd_count), .wr_count(wr_count), .err(err)
    );

    int nchecks = 0;
    int nerrors = 0;
    int exp_rd_count = 0;
    int exp_wr_count = 0;
    logic [7:0] ref_mem [1024];

    typedef struct {
        bit          fresh;
        logic [63:0] addr;
        logic [63:0] size;
        logic [7:0]  exp_data;
        logic        exp_err;
    } rd_vec_t;
    rd_vec_t tab [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        tick();
        tick();
        reset = 1'b1;
        exp_rd_count = 0;
        exp_wr_count = 0;
        tick();
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic host_read(input logic [AW-1:0] a, input string nm);
        host_addr = a;
        tick();
        chk(nm, 64'(host_rdata), 64'(ref_mem[a]));
    endtask

    // Wrapper-side read of one item; first=1 starts from idle, else from ACK.
    task automatic read_one(input logic [63:0] addr, input logic [63:0] size,
                            input bit first, input logic [7:0] exp, input string nm);
        int n;
        bit seen;
        if (first) read_enable = 1'b1; else finish_read = 1'b1;
        read_addr = addr; read_size = size;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            finish_read = 1'b0;
            n++;
            seen = read_ready[0];
        end
        chk({nm, " rd seen"}, 64'(seen), 64'd1);
        chk({nm, " rd latency"}, 64'(n), 64'(RDL + 1));
        chk({nm, " rd ready val"}, read_ready, 64'd1);
        chk({nm, " rd data"}, 64'(read_data), 64'(exp));
        exp_rd_count++;
        tick();
        chk({nm, " rd pulse width"}, read_ready, 64'd0);
        chk({nm, " rd_count"}, 64'(rd_count), 64'(exp_rd_count));
    endtask

    task automatic end_read();
        read_enable = 1'b0;
        tick();
    endtask

    task automatic write_one(input logic [63:0] addr, input logic [7:0] data,
                             input bit first, input string nm);
        int n;
        bit seen;
        if (first) write_enable = 1'b1; else finish_write = 1'b1;
        write_addr = addr; write_data = data; write_size = 64'd1;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            finish_write = 1'b0;
            n++;
            seen = write_ready[0];
        end
        chk({nm, " wr seen"}, 64'(seen), 64'd1);
        chk({nm, " wr latency"}, 64'(n), 64'(WRL + 1));
        chk({nm, " wr ready val"}, write_ready, 64'd1);
        ref_mem[addr[AW-1:0]] = data;
        exp_wr_count++;
        tick();
        chk({nm, " wr pulse width"}, write_ready, 64'd0);
        chk({nm, " wr_count"}, 64'(wr_count), 64'(exp_wr_count));
    endtask

    task automatic end_write();
        write_enable = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        bit rseen;
        bit wseen;
        bit seen;
        logic [7:0] got;
        logic [63:0] base;

        tab[0] = '{1'b1, 64'h0,           64'd1, 8'h11, 1'b0};
        tab[1] = '{1'b0, 64'h1,           64'd1, 8'h22, 1'b0};
        tab[2] = '{1'b0, 64'h2,           64'd1, 8'h33, 1'b0};
        tab[3] = '{1'b0, 64'h3,           64'd1, 8'h44, 1'b0};
        tab[4] = '{1'b1, 64'h2,           64'd2, 8'h33, 1'b1};
        tab[5] = '{1'b1, 64'h1_0000_0400, 64'd1, 8'h11, 1'b1};

        // Reset state
        reset = 1'b0;
        #1;
        chk("reset read_ready", read_ready, 64'd0);
        chk("reset write_ready", write_ready, 64'd0);
        chk("reset read_data", 64'(read_data), 64'd0);
        chk("reset rd_count", 64'(rd_count), 64'd0);
        chk("reset wr_count", 64'(wr_count), 64'd0);
        chk("reset err", 64'(err), 64'd0);
        chk("reset host_ready", 64'(host_ready), 64'd1);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Preload and dump
        host_write(10'h000, 8'h11);
        host_write(10'h001, 8'h22);
        host_write(10'h002, 8'h33);
        host_write(10'h003, 8'h44);
        host_write(10'h005, 8'h5A);
        host_write(10'h007, 8'h77);
        host_read(10'h000, "preload 0");
        host_read(10'h003, "preload 3");

        // Write stream
        write_one(64'h100, 8'hA0, 1'b1, "ws0");
        write_one(64'h101, 8'hA1, 1'b0, "ws1");
        write_one(64'h102, 8'hA2, 1'b0, "ws2");
        end_write();
        host_read(10'h100, "dump 100");
        host_read(10'h101, "dump 101");
        host_read(10'h102, "dump 102");

        // Same-address read and write landing on the same edge
        read_enable = 1'b1;  read_addr = 64'h5;  read_size = 64'd1;
        write_enable = 1'b1; write_addr = 64'h5; write_data = 8'hC3; write_size = 64'd1;
        for (int k = 0; k < RDL - WRL; k++) begin
            tick();
            if (k == 0) write_enable = 1'b1;
        end
        rseen = 1'b0; wseen = 1'b0; got = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (read_ready[0]) begin rseen = 1'b1; got = read_data; end
            if (write_ready[0]) wseen = 1'b1;
        end
        read_enable = 1'b0; write_enable = 1'b0;
        tick();
        chk("collide rd seen", 64'(rseen), 64'd1);
        chk("collide wr seen", 64'(wseen), 64'd1);
        chk("collide old byte", 64'(got), 64'h5A);
        ref_mem[5] = 8'hC3;
        exp_rd_count++; exp_wr_count++;
        read_one(64'h5, 64'd1, 1'b1, ref_mem[5], "post collide");
        end_read();
        chk("collide err", 64'(err), 64'd0);

        // Randomized write-then-readback against the memory mirror
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, 3);
            base = 64'h200 + 64'($urandom_range(0, 500));
            for (int k = 0; k < n; k++)
                write_one(base + 64'(k), 8'($urandom), k == 0, "rnd");
            end_write();
            for (int k = n - 1; k >= 0; k--)
                read_one(base + 64'(k), 64'd1, k == n - 1,
                         ref_mem[base[AW-1:0] + AW'(k)], "rnd");
            end_read();
            host_read(base[AW-1:0] + AW'($urandom_range(0, n - 1)), "rnd host");
        end
        chk("random err", 64'(err), 64'd0);

        // Table-driven read stream plus size/range error rows
        for (int i = 0; i < 6; i++) begin
            if (tab[i].fresh) begin
                if (i > 0) end_read();
                do_reset();
                chk("table err after reset", 64'(err), 64'd0);
            end
            read_one(tab[i].addr, tab[i].size, tab[i].fresh, tab[i].exp_data, "table");
            chk("table err", 64'(err), 64'(tab[i].exp_err));
        end
        end_read();

        // Host write while the read channel is busy is dropped
        do_reset();
        read_enable = 1'b1; read_addr = 64'h0; read_size = 64'd1;
        tick();
        host_we = 1'b1; host_addr = 10'h007; host_wdata = 8'hEE;
        chk("busy host_ready", 64'(host_ready), 64'd0);
        tick();
        host_we = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            seen = read_ready[0];
            if (!seen) begin tick(); n++; end
        end
        chk("busy read seen", 64'(seen), 64'd1);
        chk("busy read data", 64'(read_data), 64'h11);
        tick();
        end_read();
        host_read(10'h007, "dropped host write");
        chk("dropped host err", 64'(err), 64'd1);

        // finish_read during WAIT is flagged and ignored
        do_reset();
        read_enable = 1'b1; read_addr = 64'h1; read_size = 64'd1;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            finish_read = (n == 1);
            if (n == 1) read_addr = 64'h3;
            seen = read_ready[0];
        end
        finish_read = 1'b0;
        chk("early finish seen", 64'(seen), 64'd1);
        chk("early finish latency", 64'(n), 64'(RDL + 1));
        chk("early finish data", 64'(read_data), 64'h22);
        chk("early finish err", 64'(err), 64'd1);
        tick();
        end_read();

        // Reset during write WAIT: no commit, outputs cleared
        write_enable = 1'b1; write_addr = 64'h100; write_data = 8'h5F; write_size = 64'd1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst write_ready", write_ready, 64'd0);
        chk("midrst host_ready", 64'(host_ready), 64'd1);
        chk("midrst rd_count", 64'(rd_count), 64'd0);
        chk("midrst wr_count", 64'(wr_count), 64'd0);
        chk("midrst err", 64'(err), 64'd0);
        write_enable = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        host_read(10'h100, "midrst target byte");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
